// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised multi-cycle CPU core.
// Covers opcodes, control-state encoding and flag bit positions.
`default_nettype none

package cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_MOV  = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JC   = 4'hC;
   localparam logic [3:0] OP_JNZ  = 4'hD;
   localparam logic [3:0] OP_CMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;

   function automatic logic is_flag_op(input logic [3:0] op);
      return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_CMP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic result with carry-or-borrow and zero.
`default_nettype none

module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [3:0]        op_i,
   output logic [DATA_W-1:0] y_o,
   output logic              c_o,
   output logic              z_o
);

   logic [DATA_W:0] ext;

   // Extra top bit holds carry for ADD and borrow for SUB/CMP.
   always_comb begin
      ext = '0;
      case (op_i)
         OP_ADD:         ext = {1'b0, a_i} + {1'b0, b_i};
         OP_SUB, OP_CMP: ext = {1'b0, a_i} - {1'b0, b_i};
         OP_AND:         ext = {1'b0, a_i & b_i};
         OP_OR:          ext = {1'b0, a_i | b_i};
         OP_XOR:         ext = {1'b0, a_i ^ b_i};
         default:        ext = {1'b0, b_i};
      endcase
   end

   assign y_o = ext[DATA_W-1:0];
   assign c_o = ext[DATA_W];
   assign z_o = (ext[DATA_W-1:0] == '0);

endmodule

`default_nettype wire

// File: rtl/cpu_core_param.sv
// Multi-cycle CPU core: handshaked fetch, single-cycle execute, inline
// register file and data RAM, debug dumps of all architectural state.
`default_nettype none

module cpu_core_param
   import cpu_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int REG_AW = 3,
   parameter int PC_W   = 8,
   parameter int RAM_AW = 3,
   localparam int INSTR_W = 4 + 2*REG_AW + PC_W
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          run_i,
   output logic                          instr_req_o,
   output logic [PC_W-1:0]               instr_addr_o,
   input  logic                          instr_valid_i,
   input  logic [INSTR_W-1:0]            instr_data_i,
   output logic                          halted_o,
   output logic [3:0]                    op_out_o,
   output logic [1:0]                    flags_out_o,
   output logic [DATA_W*(2**REG_AW)-1:0] reg_dump_o,
   output logic [DATA_W*(2**RAM_AW)-1:0] ram_dump_o
);

   localparam int NREG = 2**REG_AW;
   localparam int NRAM = 2**RAM_AW;

   logic [1:0]         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [1:0]         flags_q, flags_d;
   logic               pend_q, pend_d;
   logic [DATA_W-1:0]  regs_q [NREG];
   logic [DATA_W-1:0]  ram_q  [NRAM];

   logic [3:0]         op;
   logic [REG_AW-1:0]  rd;
   logic [REG_AW-1:0]  rs;
   logic [PC_W-1:0]    imm;
   logic [DATA_W-1:0]  rd_val;
   logic [DATA_W-1:0]  rs_val;
   logic [RAM_AW-1:0]  ram_addr;
   logic [PC_W-1:0]    pc_inc;
   logic [DATA_W-1:0]  alu_y;
   logic               alu_c;
   logic               alu_z;
   logic               fetch_acc;
   logic               reg_we;
   logic [DATA_W-1:0]  reg_wdata;
   logic               ram_we;

   assign op       = ir_q[INSTR_W-1 -: 4];
   assign rd       = ir_q[2*REG_AW+PC_W-1 -: REG_AW];
   assign rs       = ir_q[REG_AW+PC_W-1 -: REG_AW];
   assign imm      = ir_q[PC_W-1:0];
   assign rd_val   = regs_q[rd];
   assign rs_val   = regs_q[rs];
   assign ram_addr = RAM_AW'(rs_val);
   assign pc_inc   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i  (rd_val),
      .b_i  (rs_val),
      .op_i (op),
      .y_o  (alu_y),
      .c_o  (alu_c),
      .z_o  (alu_z)
   );

   // A raised request is latched in pend_q so a falling run cannot withdraw it.
   assign instr_req_o = (state_q == ST_FETCH) & (run_i | pend_q);
   assign fetch_acc   = instr_req_o & instr_valid_i;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      flags_d   = flags_q;
      pend_d    = pend_q;
      reg_we    = 1'b0;
      reg_wdata = alu_y;
      ram_we    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (fetch_acc) begin
               ir_d    = instr_data_i;
               state_d = ST_EXEC;
               pend_d  = 1'b0;
            end else begin
               pend_d  = instr_req_o;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            case (op)
               OP_LDI: begin
                  reg_we    = 1'b1;
                  reg_wdata = imm[DATA_W-1:0];
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: reg_we = 1'b1;
               OP_MOV: begin
                  reg_we    = 1'b1;
                  reg_wdata = rs_val;
               end
               OP_LD: begin
                  reg_we    = 1'b1;
                  reg_wdata = ram_q[ram_addr];
               end
               OP_ST:   ram_we = 1'b1;
               OP_JMP:  pc_d = imm;
               OP_JZ:   if (flags_q[FLAG_Z])  pc_d = imm;
               OP_JC:   if (flags_q[FLAG_C])  pc_d = imm;
               OP_JNZ:  if (!flags_q[FLAG_Z]) pc_d = imm;
               OP_HALT: begin
                  state_d = ST_HALT;
                  pc_d    = pc_q;
               end
               default: ;
            endcase
            if (is_flag_op(op)) begin
               flags_d[FLAG_C] = alu_c;
               flags_d[FLAG_Z] = alu_z;
            end
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         flags_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (reg_we) begin
         regs_q[rd] <= reg_wdata;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NRAM; i++) ram_q[i] <= '0;
      end else if (ram_we) begin
         ram_q[ram_addr] <= rd_val;
      end
   end

   assign instr_addr_o = pc_q;
   assign halted_o     = (state_q == ST_HALT);
   assign op_out_o     = op;
   assign flags_out_o  = flags_q;

   for (genvar g = 0; g < NREG; g++) begin : g_reg_dump
      assign reg_dump_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

   for (genvar g = 0; g < NRAM; g++) begin : g_ram_dump
      assign ram_dump_o[g*DATA_W +: DATA_W] = ram_q[g];
   end

endmodule

`default_nettype wire

// File: tb/tb_cpu_core_param.sv
// Scenario bench for cpu_core_param; fetch addresses are scoreboarded.
`default_nettype none

module tb_cpu_core_param;
   import cpu_pkg::*;

   localparam int DATA_W  = 4;
   localparam int REG_AW  = 3;
   localparam int PC_W    = 8;
   localparam int RAM_AW  = 3;
   localparam int INSTR_W = 4 + 2*REG_AW + PC_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic auto_valid = 1'b1;
   logic man_valid = 1'b0;

   logic               instr_req;
   logic               instr_valid;
   logic [PC_W-1:0]    instr_addr;
   logic [INSTR_W-1:0] instr_data;
   logic               halted;
   logic [3:0]         op_out;
   logic [1:0]         flags_out;
   logic [31:0]        reg_dump;
   logic [31:0]        ram_dump;

   logic [INSTR_W-1:0] pmem [256];
   logic [PC_W-1:0]    exp_q [$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign instr_valid = auto_valid ? instr_req : man_valid;
   assign instr_data  = pmem[instr_addr];

   cpu_core_param #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .RAM_AW(RAM_AW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .run_i(run),
      .instr_req_o(instr_req), .instr_addr_o(instr_addr),
      .instr_valid_i(instr_valid), .instr_data_i(instr_data),
      .halted_o(halted), .op_out_o(op_out), .flags_out_o(flags_out),
      .reg_dump_o(reg_dump), .ram_dump_o(ram_dump)
   );

   // Each accepted fetch must match the next address the scenario predicted.
   always @(negedge clk) begin : mon
      logic [PC_W-1:0] e;
      if (!rst && instr_req && instr_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL fetch_addr: unexpected fetch at %0h, none expected", instr_addr);
         end else begin
            e = exp_q.pop_front();
            if (instr_addr !== e) begin
               n_err++;
               $display("FAIL fetch_addr: got %0h want %0h", instr_addr, e);
            end
         end
      end
   end

   function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input int rd,
                                              input int rs, input logic [7:0] imm);
      return {op, 3'(rd), 3'(rs), imm};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic begin_test();
      rst = 1'b1;
      run = 1'b0;
      auto_valid = 1'b1;
      man_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 256; i++) pmem[i] = '0;
      step(1);
   endtask

   task automatic test_reset();
      begin_test();
      n_cmp++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %0h want 0", instr_addr); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %0b want 0", halted); end
      n_cmp++; if (op_out !== 4'h0) begin n_err++; $display("FAIL rst_op: got %0h want 0", op_out); end
      n_cmp++; if (flags_out !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %0b want 00", flags_out); end
      n_cmp++; if (reg_dump !== 32'h0) begin n_err++; $display("FAIL rst_regs: got %0h want 0", reg_dump); end
      n_cmp++; if (ram_dump !== 32'h0) begin n_err++; $display("FAIL rst_ram: got %0h want 0", ram_dump); end
      n_cmp++; if (instr_req !== 1'b0) begin n_err++; $display("FAIL rst_req_run0: got %0b want 0", instr_req); end
      run = 1'b1; #1;
      n_cmp++; if (instr_req !== 1'b1) begin n_err++; $display("FAIL rst_req_run1: got %0b want 1", instr_req); end
      run = 1'b0;
   endtask

   task automatic test_add();
      begin_test();
      pmem[0] = enc(OP_LDI, 1, 0, 8'h09);
      pmem[1] = enc(OP_LDI, 2, 0, 8'h09);
      pmem[2] = enc(OP_ADD, 1, 2, 8'h00);
      pmem[3] = enc(OP_HALT, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
      rst = 1'b0; run = 1'b1;
      step(2);
      n_cmp++; if (reg_dump[4 +: 4] !== 4'h9) begin n_err++; $display("FAIL add_ldi_r1: got %0h want 9", reg_dump[4 +: 4]); end
      n_cmp++; if (op_out !== OP_LDI) begin n_err++; $display("FAIL add_op: got %0h want 1", op_out); end
      step(2);
      n_cmp++; if (reg_dump[8 +: 4] !== 4'h9) begin n_err++; $display("FAIL add_ldi_r2: got %0h want 9", reg_dump[8 +: 4]); end
      step(2);
      n_cmp++; if (reg_dump[4 +: 4] !== 4'h2) begin n_err++; $display("FAIL add_r1: got %0h want 2", reg_dump[4 +: 4]); end
      n_cmp++; if (flags_out !== 2'b10) begin n_err++; $display("FAIL add_flags: got %0b want 10", flags_out); end
      n_cmp++; if (instr_addr !== 8'h03) begin n_err++; $display("FAIL add_pc: got %0h want 3", instr_addr); end
      step(2);
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL add_halted: got %0b want 1", halted); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL add_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_branch();
      begin_test();
      pmem[0]     = enc(OP_LDI, 3, 0, 8'h05);
      pmem[1]     = enc(OP_CMP, 3, 3, 8'h00);
      pmem[2]     = enc(OP_JZ,  0, 0, 8'h20);
      pmem[8'h20] = enc(OP_JNZ, 0, 0, 8'h40);
      pmem[8'h21] = enc(OP_HALT, 0, 0, 8'h00);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h20); exp_q.push_back(8'h21);
      rst = 1'b0; run = 1'b1;
      step(6);
      n_cmp++; if (instr_addr !== 8'h20) begin n_err++; $display("FAIL jz_taken: got %0h want 20", instr_addr); end
      n_cmp++; if (reg_dump[12 +: 4] !== 4'h5) begin n_err++; $display("FAIL cmp_nowrite: got %0h want 5", reg_dump[12 +: 4]); end
      n_cmp++; if (flags_out !== 2'b01) begin n_err++; $display("FAIL cmp_flags: got %0b want 01", flags_out); end
      step(2);
      n_cmp++; if (instr_addr !== 8'h21) begin n_err++; $display("FAIL jnz_fall: got %0h want 21", instr_addr); end
      step(2);
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL br_halted: got %0b want 1", halted); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL br_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_alu();
      begin_test();
      pmem[0]  = enc(OP_LDI, 1, 0, 8'h0C);
      pmem[1]  = enc(OP_LDI, 2, 0, 8'h0A);
      pmem[2]  = enc(OP_MOV, 3, 1, 8'h00);
      pmem[3]  = enc(OP_AND, 3, 2, 8'h00);
      pmem[4]  = enc(OP_MOV, 4, 1, 8'h00);
      pmem[5]  = enc(OP_OR,  4, 2, 8'h00);
      pmem[6]  = enc(OP_MOV, 5, 1, 8'h00);
      pmem[7]  = enc(OP_XOR, 5, 2, 8'h00);
      pmem[8]  = enc(OP_MOV, 6, 2, 8'h00);
      pmem[9]  = enc(OP_SUB, 6, 1, 8'h00);
      pmem[10] = enc(OP_SUB, 1, 1, 8'h00);
      pmem[11] = enc(OP_HALT, 0, 0, 8'h00);
      for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
      rst = 1'b0; run = 1'b1;
      step(16);
      n_cmp++; if (flags_out !== 2'b00) begin n_err++; $display("FAIL xor_flags: got %0b want 00", flags_out); end
      step(4);
      n_cmp++; if (flags_out !== 2'b10) begin n_err++; $display("FAIL sub_borrow: got %0b want 10", flags_out); end
      step(2);
      n_cmp++; if (flags_out !== 2'b01) begin n_err++; $display("FAIL sub_self: got %0b want 01", flags_out); end
      step(2);
      n_cmp++; if (reg_dump !== 32'h0E6E_8A00) begin n_err++; $display("FAIL alu_regs: got %08h want 0e6e8a00", reg_dump); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL alu_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_ram();
      begin_test();
      pmem[0] = enc(OP_LDI, 1, 0, 8'h0A);
      pmem[1] = enc(OP_LDI, 3, 0, 8'h06);
      pmem[2] = enc(OP_ST,  1, 3, 8'h00);
      pmem[3] = enc(OP_LD,  4, 3, 8'h00);
      pmem[4] = enc(OP_HALT, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
      rst = 1'b0; run = 1'b1;
      step(6);
      n_cmp++; if (ram_dump[24 +: 4] !== 4'hA) begin n_err++; $display("FAIL st_word6: got %0h want a", ram_dump[24 +: 4]); end
      step(2);
      n_cmp++; if (reg_dump[16 +: 4] !== 4'hA) begin n_err++; $display("FAIL ld_r4: got %0h want a", reg_dump[16 +: 4]); end
      n_cmp++; if (ram_dump !== 32'h0A00_0000) begin n_err++; $display("FAIL ram_others: got %08h want 0a000000", ram_dump); end
      step(2);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ram_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_stall();
      begin_test();
      auto_valid = 1'b0;
      pmem[0] = enc(OP_LDI, 5, 0, 8'h07);
      pmem[1] = enc(OP_LDI, 6, 0, 8'h03);
      pmem[2] = enc(OP_HALT, 0, 0, 8'h00);
      exp_q.push_back(8'h00);
      rst = 1'b0; run = 1'b1;
      step(1);
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         n_cmp++; if (instr_req !== 1'b1) begin n_err++; $display("FAIL stall_req_held: cyc %0d got %0b want 1", i, instr_req); end
         n_cmp++; if (instr_addr !== 8'h00 || op_out !== 4'h0) begin n_err++; $display("FAIL stall_stable: cyc %0d got pc %0h op %0h want 0/0", i, instr_addr, op_out); end
      end
      man_valid = 1'b1;
      step(1);
      man_valid = 1'b0;
      n_cmp++; if (op_out !== OP_LDI) begin n_err++; $display("FAIL stall_accept: got %0h want 1", op_out); end
      step(1);
      n_cmp++; if (reg_dump[20 +: 4] !== 4'h7) begin n_err++; $display("FAIL stall_r5: got %0h want 7", reg_dump[20 +: 4]); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (instr_req !== 1'b0 || instr_addr !== 8'h01) begin n_err++; $display("FAIL run0_noreq: cyc %0d got req %0b pc %0h want 0/1", i, instr_req, instr_addr); end
         step(1);
      end
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      run = 1'b1; auto_valid = 1'b1;
      step(4);
      n_cmp++; if (reg_dump[24 +: 4] !== 4'h3) begin n_err++; $display("FAIL stall_r6: got %0h want 3", reg_dump[24 +: 4]); end
      step(2);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_wrap_halt();
      begin_test();
      pmem[0]     = enc(OP_JMP, 0, 0, 8'hFF);
      pmem[8'hFF] = enc(OP_NOP, 0, 0, 8'h00);
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      rst = 1'b0; run = 1'b1;
      step(2);
      n_cmp++; if (instr_addr !== 8'hFF) begin n_err++; $display("FAIL jmp_ff: got %0h want ff", instr_addr); end
      step(2);
      n_cmp++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL pc_wrap: got %0h want 0", instr_addr); end
      pmem[0] = enc(OP_HALT, 0, 0, 8'h00);
      step(2);
      for (int i = 0; i < 20; i++) begin
         run = i[0];
         step(1);
         n_cmp++; if (halted !== 1'b1 || instr_req !== 1'b0) begin n_err++; $display("FAIL halt_absorb: cyc %0d got halted %0b req %0b want 1/0", i, halted, instr_req); end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      begin_test();
      pmem[0] = enc(OP_LDI, 2, 0, 8'h03);
      pmem[1] = enc(OP_ST,  2, 2, 8'h00);
      pmem[2] = enc(OP_JMP, 0, 0, 8'h12);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      rst = 1'b0; run = 1'b1;
      step(6);
      auto_valid = 1'b0; man_valid = 1'b0;
      n_cmp++; if (instr_addr !== 8'h12 || instr_req !== 1'b1) begin n_err++; $display("FAIL mid_pending: got pc %0h req %0b want 12/1", instr_addr, instr_req); end
      n_cmp++; if (reg_dump !== 32'h0000_0300 || ram_dump !== 32'h0000_3000) begin n_err++; $display("FAIL mid_state: got regs %08h ram %08h want 00000300/00003000", reg_dump, ram_dump); end
      step(2);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (instr_addr !== 8'h00 || halted !== 1'b0) begin n_err++; $display("FAIL mid_rst_pc: got pc %0h halted %0b want 0/0", instr_addr, halted); end
      n_cmp++; if (reg_dump !== 32'h0 || ram_dump !== 32'h0) begin n_err++; $display("FAIL mid_rst_dumps: got regs %08h ram %08h want 0/0", reg_dump, ram_dump); end
      n_cmp++; if (op_out !== 4'h0 || flags_out !== 2'b00) begin n_err++; $display("FAIL mid_rst_ir: got op %0h flags %0b want 0/00", op_out, flags_out); end
      pmem[0] = enc(OP_HALT, 0, 0, 8'h00);
      exp_q.delete();
      exp_q.push_back(8'h00);
      step(1);
      rst = 1'b0; auto_valid = 1'b1;
      step(2);
      n_cmp++; if (halted !== 1'b1 || op_out !== OP_HALT) begin n_err++; $display("FAIL mid_refetch0: got halted %0b op %0h want 1/f", halted, op_out); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_sb_drain: got %0d left want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_alu();
      test_ram();
      test_stall();
      test_wrap_halt();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
